// File: rtl/narrow_to_wide_pack_fifo.sv
// Packs NARROW_WIDTH elements into WIDE_WIDTH words with per-lane strobes and queues them in a DEPTH-entry FIFO.
// Define NARROW_TO_WIDE_PACK_FIFO_PARTIAL_EN to let last_i close a partially filled word.
module narrow_to_wide_pack_fifo #(
    parameter int unsigned NARROW_WIDTH = 32,
    parameter int unsigned WIDE_WIDTH   = 64,
    parameter int unsigned DEPTH        = 4,
    localparam int unsigned RATIO       = WIDE_WIDTH / NARROW_WIDTH,
    localparam int unsigned ADDR_DEPTH  = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [NARROW_WIDTH-1:0] data_i,
    input  logic                    push_i,
    input  logic                    last_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [ADDR_DEPTH:0]     usage_o,
    output logic [WIDE_WIDTH-1:0]   data_o,
    output logic [RATIO-1:0]        strb_o,
    input  logic                    pop_i
);

    localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [ADDR_DEPTH:0] USAGE_MAX = (ADDR_DEPTH + 1)'(DEPTH);

    logic [WIDE_WIDTH-1:0] mem_q      [DEPTH];
    logic [WIDE_WIDTH-1:0] mem_d      [DEPTH];
    logic [RATIO-1:0]      strb_mem_q [DEPTH];
    logic [RATIO-1:0]      strb_mem_d [DEPTH];
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH:0]   usage_q, usage_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [WIDE_WIDTH-1:0] asm_q, asm_d, asm_nx;
    logic [RATIO-1:0]      mask_q, mask_d, mask_nx;
    logic                  push_ok, pop_ok, close, commit;

    assign full_o  = (usage_q == USAGE_MAX);
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign strb_o  = strb_mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d      = mem_q;
        strb_mem_d = strb_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usage_d    = usage_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        mask_d     = mask_q;
        asm_nx     = asm_q;
        mask_nx    = mask_q;
        commit     = 1'b0;

        for (int unsigned k = 0; k < RATIO; k++) begin
            if (LANE_W'(k) == lane_q) begin
                asm_nx[k*NARROW_WIDTH +: NARROW_WIDTH] = data_i;
                mask_nx[k] = 1'b1;
            end
        end

`ifdef NARROW_TO_WIDE_PACK_FIFO_PARTIAL_EN
        close = (lane_q == LAST_LANE) || last_i;
`else
        close = (lane_q == LAST_LANE);
`endif

        // Flush wins over push/pop; stored words stay in mem but become unreachable.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
            lane_d   = '0;
            asm_d    = '0;
            mask_d   = '0;
        end else begin
            if (push_ok) begin
                if (close) begin
                    mem_d[wr_ptr_q]      = asm_nx;
                    strb_mem_d[wr_ptr_q] = mask_nx;
                    wr_ptr_d = wr_ptr_q + ADDR_DEPTH'(1);
                    lane_d   = '0;
                    asm_d    = '0;
                    mask_d   = '0;
                    commit   = 1'b1;
                end else begin
                    asm_d  = asm_nx;
                    mask_d = mask_nx;
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ADDR_DEPTH'(1);
            end
            case ({commit, pop_ok})
                2'b10:   usage_d = usage_q + (ADDR_DEPTH + 1)'(1);
                2'b01:   usage_d = usage_q - (ADDR_DEPTH + 1)'(1);
                default: usage_d = usage_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i]      <= '0;
                strb_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
            lane_q   <= '0;
            asm_q    <= '0;
            mask_q   <= '0;
        end else begin
            mem_q      <= mem_d;
            strb_mem_q <= strb_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            mask_q     <= mask_d;
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);
    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);
`endif

endmodule
